// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: configurable data width, internal baud divider,
// optional even/odd parity and one or two stop bits, fed by a valid/ready handshake.
module uart_tx_param #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 ser_out,
  output logic                 busy,
  output logic [2:0]           state
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam int                CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]        DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]        STOP_LAST = 4'(STOP_BITS - 1);
  localparam bit                PARAMS_OK = (DATA_BITS >= 5) && (DATA_BITS <= 9) &&
                                            (CLKS_PER_BIT >= 1) &&
                                            (PARITY >= 0) && (PARITY <= 2) &&
                                            (STOP_BITS == 1 || STOP_BITS == 2);

  state_t               state_q;
  logic [CNT_W-1:0]     baud_cnt;
  logic [3:0]           bit_idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 parity_bit;
  logic                 ser_out_q;
  logic                 busy_q;
  logic                 accept;
  logic                 bit_end;
  logic                 parity_calc;

  // NOTE: tx_ready is deliberately combinational from registered state and ce so a
  // source can be accepted in the first cycle the block returns to idle.
  assign tx_ready = (state_q == ST_IDLE) && !ce;
  assign accept   = tx_valid && tx_ready;
  assign bit_end  = (baud_cnt == CNT_LAST);

  always_comb begin
    parity_calc = ^tx_data;
    if (PARITY == 2) parity_calc = ~^tx_data;
  end

  // NOTE: sequential state uses non-blocking assignments only, and every register,
  // including the shift register, is cleared by the asynchronous reset so an aborted
  // frame leaves no residue and ser_out returns high without a low glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      ser_out_q  <= 1'b1;
      busy_q     <= 1'b0;
    end else if (state_q == ST_IDLE) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      if (accept) begin
        shift_reg  <= tx_data;
        parity_bit <= parity_calc;
        state_q    <= ST_START;
        ser_out_q  <= 1'b0;
        busy_q     <= 1'b1;
      end
    end else if (!bit_end) begin
      baud_cnt <= baud_cnt + 1'b1;
    end else begin
      // Bit boundary: counter wraps and the next bit value is launched on ser_out.
      baud_cnt <= '0;
      case (state_q)
        ST_START: begin
          state_q   <= ST_DATA;
          bit_idx   <= '0;
          ser_out_q <= shift_reg[0];
        end
        ST_DATA: begin
          if (bit_idx == DATA_LAST) begin
            bit_idx <= '0;
            if (PARITY != 0) begin
              state_q   <= ST_PARITY;
              ser_out_q <= parity_bit;
            end else begin
              state_q   <= ST_STOP;
              ser_out_q <= 1'b1;
            end
          end else begin
            bit_idx   <= bit_idx + 1'b1;
            shift_reg <= shift_reg >> 1;
            ser_out_q <= shift_reg[1];
          end
        end
        ST_PARITY: begin
          state_q   <= ST_STOP;
          bit_idx   <= '0;
          ser_out_q <= 1'b1;
        end
        ST_STOP: begin
          if (bit_idx == STOP_LAST) begin
            state_q <= ST_IDLE;
            bit_idx <= '0;
            busy_q  <= 1'b0;
          end else begin
            bit_idx <= bit_idx + 1'b1;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          bit_idx   <= '0;
          ser_out_q <= 1'b1;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign ser_out = ser_out_q;
  assign busy    = busy_q;
  assign state   = state_q;

  param_legal: assert property (@(posedge clk) PARAMS_OK);

endmodule

// File: tb/tb_uart_tx_param.sv
// Scoreboard bench: six parameter sets run side by side, each with random and directed
// stimulus, a frame-level reference model and an independent serial-line monitor.
module tb_uart_tx_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp    = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int p_db(input int g);
    case (g)
      0, 1, 2: return 8;
      3:       return 7;
      4:       return 9;
      default: return 5;
    endcase
  endfunction

  function automatic int p_cpb(input int g);
    case (g)
      0, 1, 2: return 4;
      3:       return 1;
      4:       return 3;
      default: return 2;
    endcase
  endfunction

  function automatic int p_par(input int g);
    case (g)
      0, 3:    return 0;
      1, 4:    return 1;
      default: return 2;
    endcase
  endfunction

  function automatic int p_sb(input int g);
    case (g)
      0, 1, 2: return 1;
      default: return 2;
    endcase
  endfunction

  function automatic logic [8:0] p_word(input int g, input int i);
    case (g)
      0:       return (i == 0) ? 9'h0A5 : 9'h05A;
      1:       return (i == 0) ? 9'h007 : 9'h000;
      2:       return (i == 0) ? 9'h007 : 9'h0FF;
      3:       return (i == 0) ? 9'h055 : 9'h02A;
      4:       return (i == 0) ? 9'h1FF : 9'h100;
      default: return (i == 0) ? 9'h015 : 9'h00A;
    endcase
  endfunction

  for (genvar g = 0; g < 6; g++) begin : gen_cfg
    localparam int DB  = p_db(g);
    localparam int CPB = p_cpb(g);
    localparam int PAR = p_par(g);
    localparam int SB  = p_sb(g);
    localparam int N   = (1 + DB + ((PAR != 0) ? 1 : 0) + SB) * CPB;

    logic          rst_n;
    logic          ce;
    logic          tx_valid;
    logic          tx_ready;
    logic          ser_out;
    logic          busy;
    logic [DB-1:0] tx_data;
    logic [2:0]    state;
    logic [8:0]    sb_q[$];
    int            cyc     = 0;
    int            free_at = 0;

    uart_tx_param #(
      .DATA_BITS   (DB),
      .CLKS_PER_BIT(CPB),
      .PARITY      (PAR),
      .STOP_BITS   (SB)
    ) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ce      (ce),
      .tx_data (tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .ser_out (ser_out),
      .busy    (busy),
      .state   (state)
    );

    // One clock of stimulus; the model decides readiness and pushes accepted words.
    task automatic step(input logic v, input logic [8:0] d, input logic c, output logic acc);
      logic       exp_rdy;
      logic [8:0] w;
      tx_valid = v;
      tx_data  = d[DB-1:0];
      ce       = c;
      #1;
      exp_rdy = (cyc >= free_at) && !c;
      check($sformatf("cfg%0d tx_ready edge %0d", g, cyc), 64'(tx_ready), 64'(exp_rdy));
      acc = exp_rdy && v;
      if (acc) begin
        w = '0;
        w[DB-1:0] = d[DB-1:0];
        sb_q.push_back(w);
        free_at = cyc + N + 1;
      end
      @(posedge clk);
      #1;
      cyc++;
    endtask

    task automatic send(input logic [8:0] d);
      logic acc;
      acc = 1'b0;
      for (int i = 0; i < 4 * N + 4 && !acc; i++) step(1'b1, d, 1'b0, acc);
      check($sformatf("cfg%0d word accepted", g), 64'(acc), 64'd1);
    endtask

    initial begin : stim
      logic acc;
      rst_n    = 1'b0;
      ce       = 1'b0;
      tx_valid = 1'b0;
      tx_data  = '0;
      @(posedge clk);
      #1;
      check($sformatf("cfg%0d reset idle", g), 64'({ser_out, busy, state}), 64'(5'b10000));
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Directed words with tx_valid held high: second accept must follow back-to-back.
      send(p_word(g, 0));
      send(p_word(g, 1));

      repeat (300) step(($urandom % 4) != 0, 9'($urandom), ($urandom % 8) == 0, acc);

      // ce raised mid-frame: frame completes, nothing new accepted while ce is high.
      send(9'($urandom));
      repeat (10) step(1'b0, 9'($urandom), 1'b0, acc);
      repeat (2 * N) step(1'b1, 9'($urandom), 1'b1, acc);
      check($sformatf("cfg%0d idle with ce high", g), 64'({ser_out, busy}), 64'(2'b10));

      // Asynchronous reset in the middle of the data bits.
      send(9'($urandom));
      repeat (CPB + 2) step(1'b0, 9'($urandom), 1'b0, acc);
      rst_n = 1'b0;
      #1;
      check($sformatf("cfg%0d async reset", g), 64'({ser_out, busy, state}), 64'(5'b10000));
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n   = 1'b1;
      cyc    += 2;
      free_at = cyc;
      send(9'($urandom));

      while (cyc < free_at + 2) step(1'b0, 9'($urandom), 1'b0, acc);
      check($sformatf("cfg%0d scoreboard drained", g), 64'(sb_q.size()), 64'd0);
      done_cnt++;
    end

    initial begin : monitor
      logic [63:0] got;
      logic [63:0] exp_v;
      logic [15:0] fb;
      logic [8:0]  w;
      logic        busy_all;
      logic        aborted;
      int          nb;
      forever begin
        @(negedge clk);
        if (rst_n && ser_out === 1'b0) begin
          check($sformatf("cfg%0d frame expected", g), 64'(sb_q.size() > 0), 64'd1);
          if (sb_q.size() > 0) begin
            w  = sb_q.pop_front();
            fb = '0;
            nb = 1;
            for (int i = 0; i < DB; i++) begin
              fb[nb] = w[i];
              nb++;
            end
            if (PAR != 0) begin
              fb[nb] = (PAR == 1) ? ^w[DB-1:0] : ~^w[DB-1:0];
              nb++;
            end
            for (int i = 0; i < SB; i++) begin
              fb[nb] = 1'b1;
              nb++;
            end
            exp_v = '0;
            for (int k = 0; k < N; k++) exp_v[k] = fb[k / CPB];
            got      = '0;
            busy_all = 1'b1;
            aborted  = 1'b0;
            for (int k = 0; k < N; k++) begin
              if (k > 0) @(negedge clk);
              if (!rst_n) begin
                aborted = 1'b1;
                break;
              end
              got[k]   = ser_out;
              busy_all = busy_all & busy;
            end
            if (!aborted) begin
              check($sformatf("cfg%0d frame bits word %0h", g, w), got, exp_v);
              check($sformatf("cfg%0d busy during frame", g), 64'(busy_all), 64'd1);
              @(negedge clk);
              check($sformatf("cfg%0d idle after frame", g),
                    64'({ser_out, busy, state}), 64'(5'b10000));
            end
          end
        end
      end
    end
  end

  initial begin : top_ctrl
    int t;
    t = 0;
    while (done_cnt < 6 && t < 60000) begin
      @(posedge clk);
      t++;
    end
    check("all configurations finished", 64'(done_cnt), 64'd6);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised serial UART transmitter, the successor to the fixed 8N2 transmitter. Adds a configurable data width, an internal baud divider, optional even/odd parity, and 1 or 2 stop bits. A valid/ready handshake latches the data word, so input changes during a frame have no effect. Sits between the parallel data source and the CPLD serial output pin.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..9
CLKS_PER_BIT, 16, clk cycles per serial bit; legal value >= 1
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits per frame; legal value 1 or 2

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
ce  input  1  active-low chip enable; gates acceptance of new frames only
tx_data  input  DATA_BITS  parallel word; sampled only on the accept edge
tx_valid  input  1  source has a word to send
tx_ready  output  1  block can accept a word this cycle
ser_out  output  1  serial line; idles high
busy  output  1  high while a frame is in progress
state  output  3  debug FSM state: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4

Behaviour:
- Reset (rst_n low, asynchronous): ser_out=1, busy=0, state=IDLE, tx_ready=(!ce) after release, baud counter=0, bit index=0, shift register=0. Asserting reset mid-frame aborts the frame immediately; ser_out returns high with no glitch low.
- tx_ready = (state==IDLE) && !ce. This signal is combinational from registered state plus ce. No other outputs depend on inputs.
- Accept: at a rising edge with tx_valid && tx_ready, the block latches tx_data into the shift register and computes parity on the latched word. At the same edge it sets state=START, ser_out=0, busy=1.
- Baud counter: counts 0..CLKS_PER_BIT-1 in every non-IDLE state. A bit ends at the edge where count==CLKS_PER_BIT-1. At that edge the counter returns to 0 and the next bit value appears on ser_out. Every bit lasts exactly CLKS_PER_BIT cycles.
- Transitions:
  - START -> DATA.
  - DATA shifts LSB first. It stays DATA for DATA_BITS bit periods, then goes to PARITY if PARITY!=0, otherwise to STOP.
  - PARITY drives a single bit: even = XOR of data bits; odd = inverted XOR. It then goes to STOP.
  - STOP holds ser_out=1 for STOP_BITS bit periods, then goes to IDLE, with busy=0.
- Frame length: N = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles. If accept occurs at edge e0, IDLE is re-entered at edge e0+N.
- The earliest next accept is at edge e0+N+1. This guarantees one extra idle-high cycle between back-to-back frames.
- ce: sampled only in IDLE. Deasserting ce (driving it high) mid-frame does not stop the frame; the frame completes. tx_valid is ignored whenever tx_ready=0, and tx_data changes after accept have no effect.
- CLKS_PER_BIT=1: the counter is permanently 0 and the state advances every cycle.
- PARITY and STOP_BITS are elaboration-time constants. Illegal values are trapped by a simulation-time assertion.

Test Plan:
1. DATA_BITS=8, CLKS_PER_BIT=4, PARITY=0, STOP_BITS=1; send 0xA5 with ce=0.
   -> ser_out bit sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles.
   -> tx_ready low for 40 cycles, high again at edge e0+40.
   -> tx_data changed to 0x00 at e0+2 has no effect on the frame.
2. PARITY=1 (even), 0x07 -> parity bit 1. PARITY=2 (odd), 0x07 -> parity bit 0. PARITY=1, 0x00 -> parity bit 0.
   -> Each frame is 44 cycles long at CLKS_PER_BIT=4.
3. STOP_BITS=2, DATA_BITS=7, CLKS_PER_BIT=1; tx_valid held high with 0x55 then 0x2A.
   -> Each frame is 10 cycles with two high stop cycles.
   -> Exactly one idle-high cycle between frames.
   -> The second accept occurs at edge e0+11.
4. ce=1 with tx_valid=1 in IDLE -> tx_ready=0, ser_out stays 1, nothing sent.
   Raise ce to 1 at cycle 10 of a frame -> that frame completes normally and no new frame is accepted afterwards.
5. Assert rst_n low asynchronously mid-DATA (between clock edges).
   -> ser_out=1 and state=0 immediately, busy=0.
   -> After release with ce=0, tx_ready=1 and the next frame transmits correctly from its start bit.
